// File: rtl/jtag_master.sv
// Bit-level JTAG initiator: turns TMS-sequence / shift commands into TCK/TMS/TDI
// waveforms and collects TDO into a response word. No TAP state is tracked here.
module jtag_master #(
    parameter int DIV    = 4,
    parameter int MAXLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [5:0]        cmd_len,
    input  logic [MAXLEN-1:0] cmd_tms,
    input  logic [MAXLEN-1:0] cmd_tdi,
    input  logic              cmd_exit,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MAXLEN-1:0] rsp_tdo,
    output logic              busy,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    input  logic              jtag_tdo
);

    localparam int              PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PH_LAST = PW'(DIV - 1);
    localparam logic [5:0]      LEN_MAX = 6'(MAXLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_phase;
    logic [5:0]          r_bit;
    logic [5:0]          r_len;
    logic                r_op;
    logic                r_exit;
    logic [MAXLEN-1:0]   r_tms_data;
    logic [MAXLEN-1:0]   r_tdi_data;
    logic [MAXLEN-1:0]   r_tdo;
    logic                r_tck;
    logic                r_tms;
    logic                r_tdi;
    logic                r_rsp_valid;
    logic                r_cmd_ready;
    logic                r_busy;

    logic [5:0]          w_cmd_len;
    logic                w_accept;
    logic                w_phase_end;
    logic                w_last;
    logic [5:0]          w_bit_next;
    logic [MAXLEN-1:0]   w_tdo_mask;

    function automatic logic f_bit(input logic [MAXLEN-1:0] d, input logic [5:0] idx);
        logic [MAXLEN-1:0] sh;
        sh = d >> idx;
        return sh[0];
    endfunction

    // SHIFT keeps TMS low except optionally on the final bit to leave Shift-xR.
    function automatic logic f_tms(input logic op, input logic ex,
                                   input logic [MAXLEN-1:0] tmsd,
                                   input logic [5:0] idx, input logic [5:0] len);
        if (op)
            return (idx == len - 6'd1) ? ex : 1'b0;
        return f_bit(tmsd, idx);
    endfunction

    function automatic logic f_tdi(input logic op, input logic [MAXLEN-1:0] tdid,
                                   input logic [5:0] idx);
        return op ? f_bit(tdid, idx) : 1'b0;
    endfunction

    assign w_cmd_len   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_phase_end = (r_phase == PH_LAST);
    assign w_last      = (r_bit == r_len - 6'd1);
    assign w_bit_next  = r_bit + 6'd1;
    assign w_tdo_mask  = MAXLEN'(1) << r_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_bit       <= '0;
            r_len       <= '0;
            r_op        <= 1'b0;
            r_exit      <= 1'b0;
            r_tms_data  <= '0;
            r_tdi_data  <= '0;
            r_tdo       <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tck <= 1'b0;
                    if (w_accept) begin
                        r_op        <= cmd_op;
                        r_len       <= w_cmd_len;
                        r_exit      <= cmd_exit;
                        r_tms_data  <= cmd_tms;
                        r_tdi_data  <= cmd_tdi;
                        r_tdo       <= '0;
                        r_phase     <= '0;
                        r_bit       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_cmd_len == 6'd0) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_tms   <= f_tms(cmd_op, cmd_exit, cmd_tms, 6'd0, w_cmd_len);
                            r_tdi   <= f_tdi(cmd_op, cmd_tdi, 6'd0);
                            r_state <= S_LOW;
                        end
                    end
                end

                S_LOW: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_tck   <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end

                // TDO is sampled as late as possible in the high phase so the
                // target's rising-edge update has had DIV cycles to settle.
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_tck   <= 1'b0;
                        r_tdo   <= r_tdo | (jtag_tdo ? w_tdo_mask : '0);
                        if (!w_last) begin
                            r_bit   <= w_bit_next;
                            r_tms   <= f_tms(r_op, r_exit, r_tms_data, w_bit_next, r_len);
                            r_tdi   <= f_tdi(r_op, r_tdi_data, w_bit_next);
                            r_state <= S_LOW;
                        end else begin
                            r_tdi       <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end

                S_RESP: begin
                    r_tck <= 1'b0;
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_tdo   = r_tdo;
    assign busy      = r_busy;
    assign jtag_tck  = r_tck;
    assign jtag_tms  = r_tms;
    assign jtag_tdi  = r_tdi;

endmodule

// File: tb/tb_jtag_master.sv
// Directed self-checking bench for jtag_master with a small behavioural TAP model
// that logs TMS/TDI at each TCK rise and drives TDO from a pattern word.
module tb_jtag_master;

    localparam int DIV    = 4;
    localparam int MAXLEN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [5:0]        cmd_len;
    logic [MAXLEN-1:0] cmd_tms;
    logic [MAXLEN-1:0] cmd_tdi;
    logic              cmd_exit;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [MAXLEN-1:0] rsp_tdo;
    logic              busy;
    logic              jtag_tck;
    logic              jtag_tms;
    logic              jtag_tdi;
    logic              jtag_tdo = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          tap_k  = 0;
    int          base   = 0;
    logic [63:0] pat    = '0;
    logic        tms_log [256];
    logic        tdi_log [256];

    always #5 clk = ~clk;

    jtag_master #(.DIV(DIV), .MAXLEN(MAXLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_tms   (cmd_tms),
        .cmd_tdi   (cmd_tdi),
        .cmd_exit  (cmd_exit),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tdo   (rsp_tdo),
        .busy      (busy),
        .jtag_tck  (jtag_tck),
        .jtag_tms  (jtag_tms),
        .jtag_tdi  (jtag_tdi),
        .jtag_tdo  (jtag_tdo)
    );

    // TAP model: samples TMS/TDI on TCK rise and updates TDO right after it.
    always @(posedge jtag_tck) begin
        tms_log[tap_k % 256] = jtag_tms;
        tdi_log[tap_k % 256] = jtag_tdi;
        jtag_tdo = ((tap_k - base) < 64) ? pat[tap_k - base] : 1'b0;
        tap_k = tap_k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic op, input logic [5:0] len, input logic [31:0] tms,
                        input logic [31:0] tdi, input logic ex);
        @(negedge clk);
        cmd_op    = op;
        cmd_len   = len;
        cmd_tms   = tms;
        cmd_tdi   = tdi;
        cmd_exit  = ex;
        cmd_valid = 1'b1;
        base      = tap_k;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("hs_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    function automatic logic [31:0] log_word(input int b, input int n, input bit use_tdi);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n && i < 32; i++)
            w[i] = use_tdi ? tdi_log[(b + i) % 256] : tms_log[(b + i) % 256];
        return w;
    endfunction

    initial begin
        int lat;
        int n0;
        logic [31:0] held;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_len   = '0;
        cmd_tms   = '0;
        cmd_tdi   = '0;
        cmd_exit  = 1'b0;
        rsp_ready = 1'b0;

        // Reset and quiet idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tck", 32'(jtag_tck), 32'd0);
        chk("rst_tms", 32'(jtag_tms), 32'd1);
        chk("rst_tdi", 32'(jtag_tdi), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_tdo", rsp_tdo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n0 = tap_k;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_no_tck", 32'(tap_k - n0), 32'd0);
        chk("idle_tms_hold", 32'(jtag_tms), 32'd1);

        // TAP reset sequence, cycle-accurate TCK/TMS waveform
        pat = '0;
        send(1'b0, 6'd6, 32'h1F, 32'h0, 1'b0);
        chk("tr_t0_tms", 32'(jtag_tms), 32'd1);
        chk("tr_t0_busy", 32'(busy), 32'd1);
        chk("tr_t0_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int n = 1; n <= 48; n++) begin
            @(posedge clk);
            #1;
            chk("tr_tck", 32'(jtag_tck), 32'((n / 4) % 2));
            chk("tr_rsp_valid", 32'(rsp_valid), 32'(n == 48));
            if (n < 48)
                chk("tr_tms", 32'(jtag_tms), 32'((32'h1F >> (n / 8)) & 1));
        end
        chk("tr_pulses", 32'(tap_k - base), 32'd6);
        chk("tr_tms_log", log_word(base, 6, 1'b0), 32'h1F);
        chk("tr_rsp_tdo", rsp_tdo, 32'd0);
        take_rsp();

        // SHIFT 0xA5 with exit, target returns 0x3C
        pat = 64'h3C;
        send(1'b1, 6'd8, 32'h0, 32'hA5, 1'b1);
        wait_rsp(lat);
        chk("sh_latency", 32'(lat), 32'd64);
        chk("sh_pulses", 32'(tap_k - base), 32'd8);
        chk("sh_tdi_log", log_word(base, 8, 1'b1), 32'hA5);
        chk("sh_tms_log", log_word(base, 8, 1'b0), 32'h80);
        chk("sh_rsp_tdo", rsp_tdo, 32'h3C);

        // Backpressure with a competing command pending
        held = rsp_tdo;
        n0   = tap_k;
        @(negedge clk);
        cmd_op    = 1'b0;
        cmd_len   = 6'd4;
        cmd_tms   = 32'hF;
        cmd_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_tdo", rsp_tdo, held);
            chk("bp_tck", 32'(jtag_tck), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("bp_rel_busy", 32'(busy), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_pulses", 32'(tap_k - n0), 32'd0);
        chk("bp_still_idle", 32'(busy), 32'd0);

        // len=0 clears the previous nonzero capture and responds at once
        send(1'b1, 6'd0, 32'h0, 32'hFF, 1'b1);
        chk("z_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("z_rsp_tdo", rsp_tdo, 32'd0);
        chk("z_busy", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("z_no_tck", 32'(tap_k - base), 32'd0);
        take_rsp();

        // Same SHIFT against a silent stub
        pat = '0;
        send(1'b1, 6'd8, 32'h0, 32'hA5, 1'b1);
        wait_rsp(lat);
        chk("stub_latency", 32'(lat), 32'd64);
        chk("stub_rsp_tdo", rsp_tdo, 32'd0);
        take_rsp();

        // len=40 clamps to 32 bits
        pat = 64'hFFFF_FFFF_1234_5678;
        send(1'b1, 6'd40, 32'h0, 32'hDEAD_BEEF, 1'b1);
        wait_rsp(lat);
        chk("clamp_latency", 32'(lat), 32'd256);
        chk("clamp_pulses", 32'(tap_k - base), 32'd32);
        chk("clamp_tdi_log", log_word(base, 32, 1'b1), 32'hDEAD_BEEF);
        chk("clamp_tms_log", log_word(base, 32, 1'b0), 32'h8000_0000);
        chk("clamp_rsp_tdo", rsp_tdo, 32'h1234_5678);
        take_rsp();

        // len=32 with TDO stuck high
        pat = '1;
        send(1'b1, 6'd32, 32'h0, 32'h0, 1'b0);
        wait_rsp(lat);
        chk("stuck_pulses", 32'(tap_k - base), 32'd32);
        chk("stuck_rsp_tdo", rsp_tdo, 32'hFFFF_FFFF);
        take_rsp();

        // Reset after three of eight SHIFT bits
        pat = 64'hFF;
        send(1'b1, 6'd8, 32'h0, 32'hFF, 1'b1);
        repeat (24) @(posedge clk);
        #1;
        chk("ab_pulses", 32'(tap_k - base), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ab_tck", 32'(jtag_tck), 32'd0);
        chk("ab_tms", 32'(jtag_tms), 32'd1);
        chk("ab_tdi", 32'(jtag_tdi), 32'd0);
        chk("ab_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("ab_rsp_tdo", rsp_tdo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(posedge clk);
                #1;
                if (rsp_valid === 1'b1) seen = 1'b1;
            end
            chk("ab_no_rsp", 32'(seen), 32'd0);
        end

        // Normal operation resumes after the abort
        pat = 64'h6;
        send(1'b0, 6'd3, 32'h5, 32'h0, 1'b0);
        wait_rsp(lat);
        chk("post_latency", 32'(lat), 32'd24);
        chk("post_pulses", 32'(tap_k - base), 32'd3);
        chk("post_tms_log", log_word(base, 3, 1'b0), 32'h5);
        chk("post_tdi_log", log_word(base, 3, 1'b1), 32'h0);
        chk("post_rsp_tdo", rsp_tdo, 32'h6);
        take_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- On-chip JTAG initiator (host side of the IEEE 1149.1 4-wire link).
- Converts command-word requests into TCK/TMS/TDI bit sequences and captures TDO into a response word.
- Drives the TAP-side JTAG ports of the SoC debug path (the jtag_stub today, the E203 TAP later). Also serves as the scan driver for bring-up self-test.
- Bit-level only: no TAP state tracking; the requester supplies TMS sequences.

Parameters:
- DIV, 4, TCK half-period in clk cycles (legal range ≥1); one TCK period = 2*DIV clk cycles.
- MAXLEN, 32, maximum bits per command; sets width of cmd_tms/cmd_tdi/rsp_tdo.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; handshake = cmd_valid & cmd_ready.
- cmd_op  input  1  0 = TMS_SEQ, 1 = SHIFT.
- cmd_len  input  6  bit count; 0 = empty command; values >MAXLEN are clamped to MAXLEN.
- cmd_tms  input  MAXLEN  TMS bits, LSB first (TMS_SEQ only).
- cmd_tdi  input  MAXLEN  TDI bits, LSB first (SHIFT only).
- cmd_exit  input  1  SHIFT only: drive TMS=1 on the last bit (exit Shift-xR).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response accept.
- rsp_tdo  output  MAXLEN  captured TDO, bit i = TDO sampled on TCK pulse i; bits ≥ len are 0.
- busy  output  1  high whenever not in IDLE.
- jtag_tck  output  1  generated test clock.
- jtag_tms  output  1  test mode select.
- jtag_tdi  output  1  test data to target.
- jtag_tdo  input  1  test data from target; TCK is generated here, so it is sampled directly in the clk domain.

Behaviour:
- Reset values:
  - jtag_tck=0, jtag_tms=1, jtag_tdi=0.
  - cmd_ready=1, rsp_valid=0, rsp_tdo=0, busy=0.
  - State=IDLE; bit and phase counters = 0.
- Reset mid-command:
  - Aborts immediately: outputs take reset values on the next edge.
  - No response is issued, and the partial TDO capture is discarded.
- States: IDLE, LOW, HIGH, RESP.
- IDLE:
  - jtag_tck=0; jtag_tms holds the last driven value; jtag_tdi=0.
  - On handshake at edge T: latch op/len/exit/data, clear rsp_tdo.
  - If len=0: go to RESP (rsp_valid=1 at T+1, rsp_tdo=0).
  - Else: drive bit 0 TMS/TDI, go to LOW.
- Per-bit drive:
  - TMS_SEQ: tms=cmd_tms[i], tdi=0.
  - SHIFT: tdi=cmd_tdi[i]; tms=0, except tms=cmd_exit when i=len-1.
- LOW:
  - tck=0 for DIV cycles; TMS/TDI are stable for the whole phase.
  - At phase end: tck=1, go to HIGH (TCK rising edge; target samples TMS/TDI).
- HIGH:
  - tck=1 for DIV cycles.
  - On the last clk edge of the phase: rsp_tdo[i] <= jtag_tdo, tck=0 (falling edge).
  - If i<len-1: i++, drive next bit TMS/TDI on the same edge, go to LOW.
  - Else: go to RESP, rsp_valid=1.
- Timing:
  - TMS/TDI change only coincident with TCK falling (or in IDLE).
  - TDO is captured at the end of the high phase, after the target's rising-edge update has settled.
- Latency: rsp_valid asserts exactly 2*DIV*len cycles after the accept edge (len≥1).
- RESP:
  - rsp_valid and rsp_tdo are held stable until rsp_ready=1.
  - tck stays 0 and cmd_ready=0.
  - On rsp handshake: go to IDLE; cmd_ready=1 on the next cycle. No command is accepted in the same cycle as the response handshake.
- cmd_valid while not in IDLE: ignored; command inputs are not sampled.
- Bit counter width is 6 bits with no wrap: the clamp guarantees i ≤ 31.

Test Plan:
- Reset: assert rst 2 cycles -> tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, busy=0; hold idle 20 cycles -> no TCK edges.
- TAP reset, DIV=4: TMS_SEQ len=6, cmd_tms=0x1F -> 6 TCK pulses, each 4 high/4 low; TMS=1 for pulses 0-4, 0 for pulse 5; rsp_valid at accept+48.
- SHIFT len=8, cmd_tdi=0xA5, exit=1; bench TAP model returns 0x3C LSB-first -> TDI sequence 1,0,1,0,0,1,0,1; TMS=0 on bits 0-6, 1 on bit 7; rsp_tdo=0x0000003C. Repeat against jtag_stub -> rsp_tdo=0.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid/rsp_tdo stable, tck=0, cmd_ready=0, new cmd_valid ignored; release -> cmd_ready=1 one cycle later.
- Boundaries: len=0 -> no TCK, rsp_valid next cycle, rsp_tdo=0. len=40 -> exactly 32 pulses. len=32 with tdo stuck 1 -> rsp_tdo=0xFFFFFFFF.
- Reset after 3 of 8 SHIFT bits -> next cycle tck=0, tms=1, cmd_ready=1; rsp_valid never asserts; next command then runs normally.
